// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath mux selects and the one-hot instruction class produced by ctrl_decode.
package riscv_pkg;

  // Major opcodes (IR[6:0]) understood by the control FSM
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_LINK   = 2'b10;
  localparam logic [1:0] WB_IMM    = 2'b11;

  // Exactly one field is set for a supported opcode, none for an illegal one
  typedef struct packed {
    logic op;
    logic op_imm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } inst_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: one-hot instruction class plus an illegal flag.
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output inst_class_t cls_o,
  output logic        illegal_o
);

  // Map the major opcode onto its class; anything unrecognised is illegal
  always_comb begin
    cls_o     = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP:      cls_o.op     = 1'b1;
      OP_IMM:  cls_o.op_imm = 1'b1;
      LOAD:    cls_o.load   = 1'b1;
      STORE:   cls_o.store  = 1'b1;
      BRANCH:  cls_o.branch = 1'b1;
      JAL:     cls_o.jal    = 1'b1;
      JALR:    cls_o.jalr   = 1'b1;
      LUI:     cls_o.lui    = 1'b1;
      AUIPC:   cls_o.auipc  = 1'b1;
      default: illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Outputs are decoded from the state register, the instruction class and the
// handshake inputs, and are all forced low while reset is high.
// Optional: define CTRL_PERF_CNT_EN to add cycle_cnt / instret_cnt counters.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal_inst,
  output logic       mem_fault
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t      state_q, state_d;
  logic [31:0] wd_q, wd_d;
  logic        illegal_q, illegal_d;
  logic        fault_q, fault_d;
  inst_class_t cls_s;
  logic        bad_op_s;
  logic        wd_expire_s;
  logic        mem_req_s, mem_we_s, addr_sel_s, ir_we_s, pc_we_s, reg_we_s;
  logic [1:0]  pc_sel_s, src_a_s, src_b_s, alu_op_s, wb_sel_s;

  // funct fields go straight to the ALU decoder; the FSM never looks at them
  logic unused_funct_s;
  assign unused_funct_s = ^{funct3, funct7};

  ctrl_decode u_decode (
    .opcode_i  (opcode),
    .cls_o     (cls_s),
    .illegal_o (bad_op_s)
  );

  // Last waiting cycle before the memory watchdog fires (never when disabled)
  assign wd_expire_s = (MEM_TIMEOUT != 0) && (wd_q == (MEM_TIMEOUT - 32'd1));

  // Next-state, watchdog and datapath control decode
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    illegal_d  = illegal_q;
    fault_d    = fault_q;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    addr_sel_s = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    reg_we_s   = 1'b0;
    pc_sel_s   = PC_ALU;
    src_a_s    = SRCA_PC;
    src_b_s    = SRCB_RS2;
    alu_op_s   = ALU_ADD;
    wb_sel_s   = WB_ALUOUT;
    case (state_q)
      FETCH: begin
        mem_req_s = 1'b1;
        src_b_s   = SRCB_FOUR;
        if (mem_ready) begin
          ir_we_s = 1'b1;
          pc_we_s = 1'b1;
          state_d = DECODE;
        end else if (wd_expire_s) begin
          fault_d = 1'b1;
          state_d = TRAP;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      DECODE: begin
        src_a_s = SRCA_OLD_PC;
        src_b_s = SRCB_IMM;
        if (bad_op_s) begin
          illegal_d = 1'b1;
          state_d   = TRAP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cls_s.op) begin
          src_a_s  = SRCA_RS1;
          alu_op_s = ALU_FUNCT;
          state_d  = WB;
        end else if (cls_s.op_imm) begin
          src_a_s  = SRCA_RS1;
          src_b_s  = SRCB_IMM;
          alu_op_s = ALU_FUNCT;
          state_d  = WB;
        end else if (cls_s.load || cls_s.store) begin
          src_a_s = SRCA_RS1;
          src_b_s = SRCB_IMM;
          state_d = MEM;
        end else if (cls_s.branch) begin
          src_a_s  = SRCA_RS1;
          alu_op_s = ALU_BRANCH;
          if (branch_taken) begin
            pc_we_s  = 1'b1;
            pc_sel_s = PC_ALUOUT;
          end else begin
            pc_we_s = 1'b0;
          end
          state_d = FETCH;
        end else if (cls_s.jal) begin
          pc_we_s  = 1'b1;
          pc_sel_s = PC_ALUOUT;
          state_d  = WB;
        end else if (cls_s.jalr) begin
          src_a_s = SRCA_RS1;
          src_b_s = SRCB_IMM;
          pc_we_s = 1'b1;
          state_d = WB;
        end else if (cls_s.lui) begin
          state_d = WB;
        end else if (cls_s.auipc) begin
          src_a_s = SRCA_OLD_PC;
          src_b_s = SRCB_IMM;
          state_d = WB;
        end else begin
          // IR is stable from DECODE on, so this only catches corruption
          illegal_d = 1'b1;
          state_d   = TRAP;
        end
      end
      MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        mem_we_s   = cls_s.store;
        if (mem_ready) begin
          state_d = cls_s.store ? FETCH : WB;
        end else if (wd_expire_s) begin
          fault_d = 1'b1;
          state_d = TRAP;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      WB: begin
        reg_we_s = 1'b1;
        if (cls_s.load) begin
          wb_sel_s = WB_MEM;
        end else if (cls_s.jal || cls_s.jalr) begin
          wb_sel_s = WB_LINK;
        end else if (cls_s.lui) begin
          wb_sel_s = WB_IMM;
        end else begin
          wb_sel_s = WB_ALUOUT;
        end
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    // Every state change starts a fresh watchdog window
    if (state_d != state_q) begin
      wd_d = '0;
    end else begin
      wd_d = wd_d;
    end
  end

  // FSM state, watchdog counter and sticky fault flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wd_q      <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  assign mem_req      = mem_req_s & ~reset;
  assign mem_we       = mem_we_s & ~reset;
  assign mem_addr_sel = addr_sel_s & ~reset;
  assign ir_we        = ir_we_s & ~reset;
  assign pc_we        = pc_we_s & ~reset;
  assign reg_we       = reg_we_s & ~reset;
  assign pc_sel       = reset ? 2'b00 : pc_sel_s;
  assign alu_src_a    = reset ? 2'b00 : src_a_s;
  assign alu_src_b    = reset ? 2'b00 : src_b_s;
  assign alu_op       = reset ? 2'b00 : alu_op_s;
  assign wb_sel       = reset ? 2'b00 : wb_sel_s;
  assign illegal_inst = illegal_q & ~reset;
  assign mem_fault    = fault_q & ~reset;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  // Free-running cycle count and retire count (entry into FETCH after work)
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if ((state_d == FETCH) && (state_q inside {EXEC, MEM, WB})) begin
        instret_q <= instret_q + 32'd1;
      end else begin
        instret_q <= instret_q;
      end
    end
  end

  assign cycle_cnt   = reset ? 32'd0 : cycle_q;
  assign instret_cnt = reset ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (watchdog enabled, MEM_TIMEOUT = 4).
// Build with CTRL_PERF_CNT_EN defined to also exercise the performance counters.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, branch_taken, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic [1:0] pc_sel, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic       illegal_inst, mem_fault;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .illegal_inst (illegal_inst),
    .mem_fault    (mem_fault)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Control bundle: {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, a, b, alu_op, reg_we, wb_sel}
  logic [15:0] ctl;
  assign ctl = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                alu_src_a, alu_src_b, alu_op, reg_we, wb_sel};

  function automatic logic [15:0] v(input logic rq, input logic we, input logic as,
                                    input logic ir, input logic pw, input logic [1:0] ps,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] op, input logic rw, input logic [1:0] wb);
    return {rq, we, as, ir, pw, ps, sa, sb, op, rw, wb};
  endfunction

  // Hand-written expected control bundles
  localparam logic [15:0] V_IDLE = 16'h0000;
  logic [15:0] F_RDY, F_WAIT, DEC, EX_OP, WB_OP, EX_LS, MEM_LD, MEM_ST, WB_LD;
  logic [15:0] EX_BT, EX_BN, EX_JAL, WB_LINKV, WB_LUIV;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    F_RDY    = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00);
    F_WAIT   = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00);
    DEC      = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00);
    EX_OP    = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00);
    WB_OP    = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
    EX_LS    = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 2'b00);
    MEM_LD   = v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    MEM_ST   = v(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    WB_LD    = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01);
    EX_BT    = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00);
    EX_BN    = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00);
    EX_JAL   = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
    WB_LINKV = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10);
    WB_LUIV  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11);

    // ---- 1. reset for two edges, then an OP instruction with zero-wait memory
    reset = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
    branch_taken = 1'b0; mem_ready = 1'b1;
    nxt(); smp();
    chk("reset_ctl", {16'h0, ctl}, {16'h0, V_IDLE});
    chk("reset_flags", {30'h0, illegal_inst, mem_fault}, 32'h0);
    nxt();
    reset = 1'b0;
    smp(); chk("op_c0_fetch", {16'h0, ctl}, {16'h0, F_RDY});  nxt();
    smp(); chk("op_c1_decode", {16'h0, ctl}, {16'h0, DEC});   nxt();
    smp(); chk("op_c2_exec", {16'h0, ctl}, {16'h0, EX_OP});   nxt();
    smp(); chk("op_c3_wb", {16'h0, ctl}, {16'h0, WB_OP});     nxt();
    // ---- 2. LOAD with three wait cycles in MEM (watchdog expiry cycle has mem_ready)
    opcode = 7'b0000011;
    smp(); chk("op_c4_fetch", {16'h0, ctl}, {16'h0, F_RDY});  nxt();
    smp(); chk("ld_decode", {16'h0, ctl}, {16'h0, DEC});      nxt();
    mem_ready = 1'b0;
    smp(); chk("ld_exec", {16'h0, ctl}, {16'h0, EX_LS});      nxt();
    for (int i = 0; i < 3; i++) begin
      smp(); chk("ld_mem_wait", {16'h0, ctl}, {16'h0, MEM_LD}); nxt();
    end
    mem_ready = 1'b1;
    smp(); chk("ld_mem_ready", {16'h0, ctl}, {16'h0, MEM_LD}); nxt();
    smp(); chk("ld_wb", {16'h0, ctl}, {16'h0, WB_LD});         nxt();
    // ---- 3. BRANCH taken then not taken, three cycles each
    opcode = 7'b1100011; branch_taken = 1'b1;
    smp(); chk("ld_back_fetch", {16'h0, ctl}, {16'h0, F_RDY}); nxt();
    smp(); chk("bt_decode", {16'h0, ctl}, {16'h0, DEC});       nxt();
    smp(); chk("bt_exec", {16'h0, ctl}, {16'h0, EX_BT});       nxt();
    branch_taken = 1'b0;
    smp(); chk("bt_fetch", {16'h0, ctl}, {16'h0, F_RDY});      nxt();
    smp(); chk("bn_decode", {16'h0, ctl}, {16'h0, DEC});       nxt();
    smp(); chk("bn_exec", {16'h0, ctl}, {16'h0, EX_BN});       nxt();
    // STORE: zero-wait, back in FETCH after four cycles
    opcode = 7'b0100011;
    smp(); chk("bn_fetch", {16'h0, ctl}, {16'h0, F_RDY});      nxt();
    smp(); chk("st_decode", {16'h0, ctl}, {16'h0, DEC});       nxt();
    smp(); chk("st_exec", {16'h0, ctl}, {16'h0, EX_LS});       nxt();
    smp(); chk("st_mem", {16'h0, ctl}, {16'h0, MEM_ST});       nxt();
    // JAL: PC from ALUOUT in EXEC, link written in WB
    opcode = 7'b1101111;
    smp(); chk("st_fetch", {16'h0, ctl}, {16'h0, F_RDY});      nxt();
    smp(); chk("jal_decode", {16'h0, ctl}, {16'h0, DEC});      nxt();
    smp(); chk("jal_exec", {16'h0, ctl}, {16'h0, EX_JAL});     nxt();
    smp(); chk("jal_wb", {16'h0, ctl}, {16'h0, WB_LINKV});     nxt();
    // LUI: nothing in EXEC, IMM written in WB
    opcode = 7'b0110111;
    smp(); chk("jal_fetch", {16'h0, ctl}, {16'h0, F_RDY});     nxt();
    smp(); chk("lui_decode", {16'h0, ctl}, {16'h0, DEC});      nxt();
    smp(); chk("lui_exec", {16'h0, ctl}, {16'h0, V_IDLE});     nxt();
    smp(); chk("lui_wb", {16'h0, ctl}, {16'h0, WB_LUIV});      nxt();
    // ---- 4. illegal opcode -> TRAP, held for 20 cycles, cleared by reset
    opcode = 7'b0000000;
    smp(); chk("ill_fetch", {16'h0, ctl}, {16'h0, F_RDY});     nxt();
    smp(); chk("ill_decode", {16'h0, ctl}, {16'h0, DEC});
    chk("ill_decode_flag", {31'h0, illegal_inst}, 32'h0);      nxt();
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("trap_ctl", {16'h0, ctl}, {16'h0, V_IDLE});
      chk("trap_illegal", {31'h0, illegal_inst}, 32'h1);
      nxt();
    end
    reset = 1'b1;
    smp(); chk("trap_reset_flag", {31'h0, illegal_inst}, 32'h0); nxt();
    reset = 1'b0; opcode = 7'b0110011; mem_ready = 1'b0;
    // ---- 5. watchdog: four FETCH cycles without mem_ready -> mem_fault
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("wd_fetch_wait", {16'h0, ctl}, {16'h0, F_WAIT});
      chk("wd_no_fault", {31'h0, mem_fault}, 32'h0);
      nxt();
    end
    smp();
    chk("wd_fault", {31'h0, mem_fault}, 32'h1);
    chk("wd_trap_ctl", {16'h0, ctl}, {16'h0, V_IDLE});
    nxt();
    reset = 1'b1;
    smp(); chk("wd_reset_flag", {31'h0, mem_fault}, 32'h0); nxt();
    // reset mid-MEM: request dropped, no register write, restart in FETCH
    reset = 1'b0; opcode = 7'b0000011; mem_ready = 1'b1;
    smp(); chk("rm_fetch", {16'h0, ctl}, {16'h0, F_RDY});  nxt();
    smp(); chk("rm_decode", {16'h0, ctl}, {16'h0, DEC});   nxt();
    mem_ready = 1'b0;
    smp(); chk("rm_exec", {16'h0, ctl}, {16'h0, EX_LS});   nxt();
    smp(); chk("rm_mem", {16'h0, ctl}, {16'h0, MEM_LD});   nxt();
    reset = 1'b1; mem_ready = 1'b1;
    smp(); chk("rm_reset_ctl", {16'h0, ctl}, {16'h0, V_IDLE}); nxt();
    reset = 1'b0;
    smp(); chk("rm_restart_fetch", {16'h0, ctl}, {16'h0, F_RDY}); nxt();
`ifdef CTRL_PERF_CNT_EN
    // ---- 6. ten back-to-back OP instructions, then cycle counter wrap
    reset = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    smp();
    chk("perf_reset_cycle", cycle_cnt, 32'h0);
    chk("perf_reset_instret", instret_cnt, 32'h0);
    nxt();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      nxt();
    end
    chk("perf_instret_10", instret_cnt, 32'd10);
    chk("perf_cycle_40", cycle_cnt, 32'd40);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    chk("perf_forced", cycle_cnt, 32'hFFFF_FFFE);
    nxt();
    chk("perf_max", cycle_cnt, 32'hFFFF_FFFF);
    nxt();
    chk("perf_wrap", cycle_cnt, 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
